// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter fetch stage.
// Holds the state encoding, word width and default PC/step values.
package pc_fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_STEP     = 32'd4;

    // Encoding is visible on the debug state output, so values are fixed.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2,
        StFault = 2'd3
    } state_e;

    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, redirect and fetch-handshake bundle of the PC stage.
// master = the PC stage itself, slave = the surrounding pipeline/fetch logic.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic              start;
    logic              halt_req;
    logic              stall;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_target;
    logic              jump;
    logic [WORD_W-1:0] jump_target;
    logic              fetch_ready;
    logic [WORD_W-1:0] pc_out;
    logic              pc_valid;
    logic [WORD_W-1:0] pc_plus_step;
    logic              misaligned;
    logic [WORD_W-1:0] fetch_count;
    logic [1:0]        state;

    modport master (
        input  start, halt_req, stall, branch_taken, branch_target,
               jump, jump_target, fetch_ready,
        output pc_out, pc_valid, pc_plus_step, misaligned, fetch_count, state
    );

    modport slave (
        output start, halt_req, stall, branch_taken, branch_target,
               jump, jump_target, fetch_ready,
        input  pc_out, pc_valid, pc_plus_step, misaligned, fetch_count, state
    );

endinterface

// File: rtl/pc_fetch_unit_add.sv
// ADD: plain combinational adder used as the PC incrementer.
// The sum wraps modulo 2^WIDTH; no carry is exported.
module ADD #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic [WIDTH-1:0] resultado
);

    assign resultado = operando1 + operando2;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, selects sequential/branch/jump next-PC,
// presents it to fetch with valid/ready and traps on misaligned redirects.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] STEP     = DEFAULT_STEP
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic              mis_q, mis_d;

    logic [WORD_W-1:0] pc_sum;
    logic              in_run;
    logic              handshake;
    logic              redirect;
    logic [WORD_W-1:0] target;

    ADD #(
        .WIDTH(WORD_W)
    ) u_add (
        .operando1(pc_q),
        .operando2(STEP),
        .resultado(pc_sum)
    );

    assign in_run    = (state_q == StRun);
    assign handshake = in_run & bus.fetch_ready & ~bus.stall;
    assign redirect  = in_run & (bus.jump | bus.branch_taken);
    // Only the winning source is checked for alignment.
    assign target    = bus.jump ? bus.jump_target : bus.branch_target;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        mis_d   = mis_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (handshake) begin
                    count_d = count_q + 1'b1;
                end
                if (redirect && !is_aligned(target)) begin
                    // Fault beats a simultaneous halt; PC keeps the old value.
                    state_d = StFault;
                    mis_d   = 1'b1;
                end else begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (handshake) begin
                        pc_d = pc_sum;
                    end
                    if (bus.halt_req) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_valid     = in_run;
    assign bus.pc_plus_step = pc_sum;
    assign bus.misaligned   = mis_q;
    assign bus.fetch_count  = count_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// traffic checked against a behavioural model of the PC stage.
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic reset;

    pc_fetch_unit_if bus_a ();
    pc_fetch_unit_if bus_w ();

    pc_fetch_unit u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    pc_fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8),
        .STEP    (32'd4)
    ) u_dut_wrap (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_w)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=idle 1=run 2=halt 3=fault.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_mode;
    logic        m_mis;

    task automatic model_reset();
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
        m_mode = 0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        case (m_mode)
            0, 2: if (bus_a.start) m_mode = 1;
            1: begin
                if (bus_a.fetch_ready && !bus_a.stall) m_cnt = m_cnt + 1;
                if (bus_a.jump || bus_a.branch_taken) begin
                    t = bus_a.jump ? bus_a.jump_target : bus_a.branch_target;
                    if (t % 4 != 0) begin
                        m_mode = 3;
                        m_mis  = 1'b1;
                    end else begin
                        m_pc = t;
                        if (bus_a.halt_req) m_mode = 2;
                    end
                end else begin
                    if (bus_a.fetch_ready && !bus_a.stall) m_pc = m_pc + 4;
                    if (bus_a.halt_req) m_mode = 2;
                end
            end
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        bus_a.start = 0; bus_a.halt_req = 0; bus_a.stall = 0;
        bus_a.branch_taken = 0; bus_a.branch_target = 0;
        bus_a.jump = 0; bus_a.jump_target = 0; bus_a.fetch_ready = 0;
        bus_w.start = 0; bus_w.halt_req = 0; bus_w.stall = 0;
        bus_w.branch_taken = 0; bus_w.branch_target = 0;
        bus_w.jump = 0; bus_w.jump_target = 0; bus_w.fetch_ready = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        model_reset();
        total++;
        if (bus_a.pc_out !== 32'h0 || bus_a.pc_valid !== 1'b0 || bus_a.misaligned !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs pc=%h valid=%b mis=%b required pc=0 valid=0 mis=0",
                     bus_a.pc_out, bus_a.pc_valid, bus_a.misaligned);
        end
        total++;
        if (bus_a.fetch_count !== 32'h0 || bus_a.state !== 2'd0) begin
            bad++;
            $display("FAIL reset_count_state cnt=%0d state=%0d required 0/0",
                     bus_a.fetch_count, bus_a.state);
        end
        total++;
        if (bus_a.pc_plus_step !== 32'h4) begin
            bad++;
            $display("FAIL reset_plus_step got=%h required=4", bus_a.pc_plus_step);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_a.fetch_ready = 1;
        cycle();
        total++;
        if (bus_a.state !== 2'd0 || bus_a.pc_valid !== 1'b0 || bus_a.pc_out !== 32'h0) begin
            bad++;
            $display("FAIL idle_hold state=%0d valid=%b pc=%h required 0/0/0",
                     bus_a.state, bus_a.pc_valid, bus_a.pc_out);
        end
        bus_a.fetch_ready = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h4, 32'h8, 32'hC};
        bus_a.start = 1;
        cycle();
        bus_a.start = 0;
        total++;
        if (bus_a.pc_valid !== 1'b1 || bus_a.pc_out !== 32'h0 || bus_a.state !== 2'd1) begin
            bad++;
            $display("FAIL start_run valid=%b pc=%h state=%0d required 1/0/1",
                     bus_a.pc_valid, bus_a.pc_out, bus_a.state);
        end
        bus_a.fetch_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (bus_a.pc_out !== exp_pc[i]) begin
                bad++;
                $display("FAIL seq_pc[%0d] got=%h required=%h", i, bus_a.pc_out, exp_pc[i]);
            end
        end
        total++;
        if (bus_a.fetch_count !== 32'd3) begin
            bad++;
            $display("FAIL seq_count got=%0d required=3", bus_a.fetch_count);
        end
    endtask

    task automatic test_stall();
        bus_a.stall = 1;
        bus_a.fetch_ready = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (bus_a.pc_out !== 32'hC || bus_a.fetch_count !== 32'd3) begin
                bad++;
                $display("FAIL stall_hold[%0d] pc=%h cnt=%0d required C/3",
                         i, bus_a.pc_out, bus_a.fetch_count);
            end
        end
        bus_a.stall = 0;
        cycle();
        total++;
        if (bus_a.pc_out !== 32'h10 || bus_a.fetch_count !== 32'd4) begin
            bad++;
            $display("FAIL stall_release pc=%h cnt=%0d required 10/4",
                     bus_a.pc_out, bus_a.fetch_count);
        end
        bus_a.fetch_ready = 0;
    endtask

    task automatic test_priority();
        bus_a.stall = 1;
        bus_a.jump = 1; bus_a.jump_target = 32'h100;
        bus_a.branch_taken = 1; bus_a.branch_target = 32'h200;
        cycle();
        total++;
        if (bus_a.pc_out !== 32'h100 || bus_a.fetch_count !== 32'd4) begin
            bad++;
            $display("FAIL jump_over_branch pc=%h cnt=%0d required 100/4",
                     bus_a.pc_out, bus_a.fetch_count);
        end
        bus_a.stall = 0;
        bus_a.jump_target = 32'h300;
        bus_a.branch_target = 32'h202;
        cycle();
        total++;
        if (bus_a.pc_out !== 32'h300 || bus_a.misaligned !== 1'b0 || bus_a.state !== 2'd1) begin
            bad++;
            $display("FAIL masked_branch_align pc=%h mis=%b state=%0d required 300/0/1",
                     bus_a.pc_out, bus_a.misaligned, bus_a.state);
        end
        bus_a.jump = 0; bus_a.branch_taken = 0;
    endtask

    task automatic test_halt();
        bus_a.fetch_ready = 1;
        bus_a.halt_req = 1;
        cycle();
        bus_a.halt_req = 0;
        total++;
        if (bus_a.pc_out !== 32'h304 || bus_a.state !== 2'd2 || bus_a.pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter pc=%h state=%0d valid=%b required 304/2/0",
                     bus_a.pc_out, bus_a.state, bus_a.pc_valid);
        end
        cycle();
        total++;
        if (bus_a.pc_out !== 32'h304 || bus_a.fetch_count !== 32'd5) begin
            bad++;
            $display("FAIL halt_frozen pc=%h cnt=%0d required 304/5",
                     bus_a.pc_out, bus_a.fetch_count);
        end
        bus_a.fetch_ready = 0;
        bus_a.start = 1;
        cycle();
        bus_a.start = 0;
        total++;
        if (bus_a.pc_out !== 32'h304 || bus_a.state !== 2'd1 || bus_a.pc_valid !== 1'b1) begin
            bad++;
            $display("FAIL halt_resume pc=%h state=%0d valid=%b required 304/1/1",
                     bus_a.pc_out, bus_a.state, bus_a.pc_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus_a.jump          = ($urandom_range(0, 7) == 0);
            bus_a.branch_taken  = ($urandom_range(0, 5) == 0);
            bus_a.jump_target   = {$urandom(), 2'b00} >> 0;
            bus_a.jump_target[1:0]   = 2'b00;
            bus_a.branch_target = $urandom();
            bus_a.branch_target[1:0] = 2'b00;
            bus_a.stall         = ($urandom_range(0, 3) == 0);
            bus_a.fetch_ready   = ($urandom_range(0, 1) == 1);
            bus_a.halt_req      = ($urandom_range(0, 19) == 0);
            bus_a.start         = ($urandom_range(0, 3) == 0);
            cycle();
            total++;
            if (bus_a.pc_out !== m_pc || bus_a.pc_plus_step !== m_pc + 32'd4) begin
                bad++;
                $display("FAIL rand_pc[%0d] pc=%h plus=%h required %h/%h",
                         i, bus_a.pc_out, bus_a.pc_plus_step, m_pc, m_pc + 32'd4);
            end
            total++;
            if (bus_a.fetch_count !== m_cnt || bus_a.state !== m_mode[1:0] ||
                bus_a.pc_valid !== (m_mode == 1) || bus_a.misaligned !== m_mis) begin
                bad++;
                $display("FAIL rand_ctrl[%0d] cnt=%0d state=%0d valid=%b mis=%b required %0d/%0d/%b/%b",
                         i, bus_a.fetch_count, bus_a.state, bus_a.pc_valid, bus_a.misaligned,
                         m_cnt, m_mode, (m_mode == 1), m_mis);
            end
        end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        logic [31:0] saved_pc;
        logic [31:0] saved_cnt;
        if (m_mode != 1) begin
            bus_a.start = 1;
            cycle();
            bus_a.start = 0;
        end
        saved_pc  = m_pc;
        saved_cnt = m_cnt;
        bus_a.branch_taken = 1; bus_a.branch_target = 32'h202;
        bus_a.halt_req = 1;
        cycle();
        idle_inputs();
        total++;
        if (bus_a.misaligned !== 1'b1 || bus_a.state !== 2'd3 || bus_a.pc_valid !== 1'b0 ||
            bus_a.pc_out !== saved_pc) begin
            bad++;
            $display("FAIL fault_enter mis=%b state=%0d valid=%b pc=%h required 1/3/0/%h",
                     bus_a.misaligned, bus_a.state, bus_a.pc_valid, bus_a.pc_out, saved_pc);
        end
        bus_a.start = 1; bus_a.jump = 1; bus_a.jump_target = 32'h40; bus_a.fetch_ready = 1;
        cycle();
        cycle();
        idle_inputs();
        total++;
        if (bus_a.state !== 2'd3 || bus_a.pc_out !== saved_pc || bus_a.fetch_count !== saved_cnt) begin
            bad++;
            $display("FAIL fault_sticky state=%0d pc=%h cnt=%0d required 3/%h/%0d",
                     bus_a.state, bus_a.pc_out, bus_a.fetch_count, saved_pc, saved_cnt);
        end
        reset = 1'b1;
        #2;
        model_reset();
        total++;
        if (bus_a.pc_out !== 32'h0 || bus_a.misaligned !== 1'b0 || bus_a.state !== 2'd0) begin
            bad++;
            $display("FAIL fault_reset pc=%h mis=%b state=%0d required 0/0/0",
                     bus_a.pc_out, bus_a.misaligned, bus_a.state);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [3];
        exp_w = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        reset = 1'b1;
        #2;
        model_reset();
        total++;
        if (bus_w.pc_out !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL wrap_reset_pc got=%h required=FFFFFFF8", bus_w.pc_out);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_w.start = 1;
        cycle();
        bus_w.start = 0;
        bus_w.fetch_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (bus_w.pc_out !== exp_w[i] || bus_w.misaligned !== 1'b0) begin
                bad++;
                $display("FAIL wrap_pc[%0d] pc=%h mis=%b required %h/0",
                         i, bus_w.pc_out, bus_w.misaligned, exp_w[i]);
            end
        end
        total++;
        if (bus_w.fetch_count !== 32'd3 || bus_w.pc_plus_step !== 32'h8) begin
            bad++;
            $display("FAIL wrap_count cnt=%0d plus=%h required 3/8",
                     bus_w.fetch_count, bus_w.pc_plus_step);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        test_reset();
        test_sequential();
        test_stall();
        test_priority();
        test_halt();
        test_random();
        test_misaligned();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage that sits directly upstream of the 32-bit PC adder (ADD); it holds the PC that ADD increments and consumes ADD's sum as the sequential next-PC.
- Selects the next PC from sequential, branch or jump sources.
- Presents the PC to instruction fetch with a valid/ready handshake.
- Provides stall, halt and misaligned-target fault handling, plus a retired-fetch counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- STEP, 32'd4, increment fed to the adder; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE.
- halt_req  input  1  stop fetching after the current handshake.
- stall  input  1  hold PC; ignored when a redirect is present.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  32  branch destination.
- jump  input  1  redirect to jump_target; wins over branch.
- jump_target  input  32  jump destination.
- fetch_ready  input  1  fetch stage accepts pc_out this cycle.
- pc_out  output  32  current PC.
- pc_valid  output  1  pc_out is valid for fetch.
- pc_plus_step  output  32  pc_out + STEP, combinational adder result, modulo 2^32.
- misaligned  output  1  sticky fault flag.
- fetch_count  output  32  number of completed handshakes.
- state  output  2  encoded FSM state, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc_out=RESET_PC, pc_valid=0, misaligned=0, fetch_count=0, state=IDLE.
- FSM states: IDLE=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3.
- IDLE:
  - pc_valid=0, PC held.
  - start=1 → RUN next cycle; pc_valid=1 from that cycle.
- RUN: pc_valid=1. Next-PC priority each cycle:
  1. jump=1: target=jump_target.
  2. else branch_taken=1: target=branch_target.
  3. else if stall=0 and fetch_ready=1: pc_out ← pc_plus_step.
  4. else: hold.
- Redirect rules:
  - A redirect is taken the same edge regardless of stall or fetch_ready; the in-flight PC is discarded.
  - fetch_count does not increment on a redirect unless fetch_ready=1 and stall=0 in that cycle.
- Handshake:
  - A fetch completes when pc_valid=1 and fetch_ready=1 and stall=0.
  - Each completed fetch increments fetch_count by 1, wrapping from 32'hFFFFFFFF to 0.
  - pc_out is stable while pc_valid=1 and no handshake or redirect occurs.
- Misaligned target:
  - If the selected redirect target has [1:0]≠2'b00: pc_out is not updated, misaligned←1, state→FAULT, pc_valid=0 next cycle.
  - Only the winning target is checked; an unaligned branch_target under an active jump is ignored.
- FAULT: pc_valid=0, all inputs ignored; exit only via reset.
- halt_req in RUN:
  - The handshake/redirect of that cycle still completes, then state→HALT.
  - HALT: pc_valid=0, PC frozen.
  - start=1 in HALT → RUN, continuing from the frozen PC.
- Simultaneous halt_req and misaligned redirect: FAULT wins.
- Wrap-around: PC 32'hFFFFFFFC + 4 = 32'h00000000, no flag raised.
- start while in RUN is ignored.
- Reset asserted mid-RUN returns everything to reset values immediately; the following fetch restarts at RESET_PC only after a new start pulse.
- Latency: redirect visible on pc_out one clock after the inputs are sampled.

Decomposition:
- Shared package:
  - state encodings (IDLE/RUN/HALT/FAULT).
  - default RESET_PC and STEP constants.
  - WORD_W=32.
- Sub-module: instantiate the existing ADD adder for pc_plus_step (operando1=pc_out, operando2=STEP). No other sub-modules.

Test Plan:
- Reset, then start, fetch_ready=1 for 3 cycles → pc_out 0→4→8→C, fetch_count=3, pc_valid=1 from cycle after start.
- PC=8, stall=1 and fetch_ready=1 for 2 cycles, then stall=0 → pc_out holds 8 for two cycles, then 32'hC; fetch_count unchanged during stall.
- PC=C, jump=1, jump_target=32'h100 and branch_taken=1, branch_target=32'h200 in the same cycle, with stall=1 → pc_out=32'h100 next cycle.
- branch_taken=1, branch_target=32'h202 → misaligned=1, state=FAULT, pc_valid=0, pc_out unchanged; start pulse has no effect; reset clears to RESET_PC.
- RESET_PC=32'hFFFFFFF8, run 3 handshakes → pc_out FFFFFFF8→FFFFFFFC→00000000→00000004, misaligned=0.
- halt_req with fetch_ready=1 at PC=4 → PC becomes 8, state=HALT, pc_valid=0; start → RUN with pc_out=8.
